// File: rtl/beam_pkg.sv
// Shared sizing and FSM encoding for the beamformer frame-to-UART sequencer.
package beam_pkg;
  localparam int DATA_W = 40;
  localparam int DEPTH  = 540;
  localparam int ADDR_W = 10;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAPTURE   = 3'd1,
    S_FETCH     = 3'd2,
    S_LOAD      = 3'd3,
    S_SEND      = 3'd4,
    S_WAIT_BUSY = 3'd5,
    S_DONE      = 3'd6
  } state_e;
endpackage

// File: rtl/beam_sample_buffer.sv
// Simple dual-port frame buffer: one write port, one read port with registered q.
module beam_sample_buffer #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 540,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/beam_frame_uart_sequencer.sv
// Captures one frame of summed samples, then streams it LSB-first to the UART
// one byte per start/busy handshake.
module beam_frame_uart_sequencer
  import beam_pkg::*;
#(
  parameter int DATA_W = beam_pkg::DATA_W,
  parameter int DEPTH  = beam_pkg::DEPTH,
  parameter int ADDR_W = beam_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sum_valid,
  input  logic [DATA_W-1:0] sum_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);
  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  typedef logic [ADDR_W:0] ptr_t;

  state_e            state_q, state_d;
  ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wcnt_q, wcnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [7:0]        txb_q, txb_d;
  logic              txs_q, txs_d, ovf_q, ovf_d, rise_q, rise_d, busy_q;

  logic              we, re, fall;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] q;

  beam_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk(clk), .we(we), .waddr(waddr), .wdata(sum_data),
    .re(re), .raddr(raddr), .q(q)
  );

  // A byte is finished only on a busy fall that follows an observed busy high.
  assign fall = rise_q && busy_q && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wcnt_q   <= '0;
      shift_q  <= '0;
      bidx_q   <= '0;
      txb_q    <= '0;
      txs_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rise_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wcnt_q   <= wcnt_d;
      shift_q  <= shift_d;
      bidx_q   <= bidx_d;
      txb_q    <= txb_d;
      txs_q    <= txs_d;
      ovf_q    <= ovf_d;
      rise_q   <= rise_d;
      busy_q   <= tx_busy;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wcnt_d   = wcnt_q;
    shift_d  = shift_q;
    bidx_d   = bidx_q;
    txb_d    = txb_q;
    txs_d    = 1'b0;
    ovf_d    = ovf_q;
    rise_d   = rise_q;
    we       = 1'b0;
    waddr    = '0;
    re       = 1'b0;
    raddr    = rd_ptr_q[ADDR_W-1:0];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (sum_valid) begin
          we       = 1'b1;
          wr_ptr_d = ptr_t'(1);
          ovf_d    = 1'b0;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (sum_valid) begin
          if (wr_ptr_q < ptr_t'(DEPTH)) begin
            we       = 1'b1;
            waddr    = wr_ptr_q[ADDR_W-1:0];
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          wcnt_d   = wr_ptr_q;
          rd_ptr_d = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        re      = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = q;
        bidx_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        txb_d   = shift_q[7:0];
        txs_d   = 1'b1;
        rise_d  = 1'b0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) rise_d = 1'b1;
        if (fall) begin
          shift_d = shift_q >> 8;
          bidx_d  = bidx_q + BW'(1);
          if (bidx_q < BW'(NB - 1)) begin
            state_d = S_SEND;
          end else begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
            state_d  = (rd_ptr_q + ptr_t'(1) == wcnt_q) ? S_DONE : S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Samples arriving while the frame is being read out are lost.
    if (sum_valid && (state_q inside {S_FETCH, S_LOAD, S_SEND, S_WAIT_BUSY}))
      ovf_d = 1'b1;
  end

  assign tx_start   = txs_q;
  assign tx_byte    = txb_q;
  assign frame_done = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign word_count = wcnt_q;
endmodule

// File: tb/tb_beam_frame_uart_sequencer.sv
// Randomized scoreboard bench: expected UART bytes are queued at capture time
// and popped by a monitor on every tx_start; a UART model drives tx_busy.
module tb_beam_frame_uart_sequencer;
  localparam int DEPTH = 540;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sum_valid;
  logic [39:0] sum_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        frame_done;
  logic        overflow;
  logic [10:0] word_count;

  always #5 clk = ~clk;

  beam_frame_uart_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sum_valid(sum_valid), .sum_data(sum_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .frame_done(frame_done), .overflow(overflow), .word_count(word_count)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic [39:0] frame[$];
  int          rise_dly = 0;
  int          busy_len = 10;
  int          epoch = 0;
  int          tx_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] rnd40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Reference: only the first DEPTH words of a frame are kept, each sent LSB byte first.
  task automatic capture();
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk);
      sum_valid = 1'b1;
      sum_data  = frame[i];
      if (i < DEPTH)
        for (int b = 0; b < 5; b++) exp_q.push_back(frame[i][8*b +: 8]);
    end
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  task automatic finish_frame(input int wc, input logic ovf);
    int t = 0;
    while (!frame_done && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done", 64'(frame_done), 64'(1));
    chk("word_count", 64'(word_count), 64'(wc));
    chk("overflow", 64'(overflow), 64'(ovf));
    chk("bytes_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_tx(input int target);
    int t = 0;
    while (tx_cnt < target && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("tx_reached", 64'(tx_cnt >= target), 64'(1));
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n && tx_start) begin
      tx_cnt++;
      if (exp_q.size() == 0) chk("extra_tx_start", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("tx_byte", 64'(tx_byte), 64'(e));
      end
    end
  end

  initial begin : uart
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin : xfer
        int         my_ep;
        logic [7:0] held;
        logic       ok;
        ok    = 1'b1;
        held  = tx_byte;
        my_ep = epoch;
        repeat (rise_dly) begin
          @(negedge clk);
          if (tx_start) ok = 1'b0;
        end
        tx_busy = 1'b1;
        repeat (busy_len) begin
          @(negedge clk);
          if (tx_start || tx_byte !== held) ok = 1'b0;
        end
        tx_busy = 1'b0;
        if (my_ep == epoch) chk("uart_handshake", 64'(ok), 64'(1));
      end
    end
  end

  initial begin
    int n, base;
    rst_n = 1'b0;
    sum_valid = 1'b0;
    sum_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 64'(tx_start), 64'(0));
    chk("rst_tx_byte", 64'(tx_byte), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_word_count", 64'(word_count), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // three known words
    rise_dly = 0; busy_len = 10;
    frame = '{40'h0504030201, 40'h0A09080706, 40'hFFEEDDCCBB};
    capture();
    finish_frame(3, 1'b0);

    // back-to-back single-word frames
    frame = '{40'h1122334455};
    capture();
    finish_frame(1, 1'b0);
    frame = '{40'hAABBCCDDEE};
    capture();
    chk("frame_done_drop", 64'(frame_done), 64'(0));
    finish_frame(1, 1'b0);

    // samples during readout are dropped but flagged
    rise_dly = 1; busy_len = 6;
    frame = '{rnd40(), rnd40()};
    base = tx_cnt;
    capture();
    wait_tx(base + 3);
    @(negedge clk); sum_valid = 1'b1; sum_data = rnd40();
    @(negedge clk); sum_data = rnd40();
    @(negedge clk); sum_valid = 1'b0;
    finish_frame(2, 1'b1);

    // slow UART: late busy rise, long busy
    rise_dly = 3; busy_len = 50;
    frame = '{rnd40()};
    capture();
    finish_frame(1, 1'b0);

    // random frames
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 12);
      rise_dly = $urandom_range(0, 4);
      busy_len = $urandom_range(1, 8);
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back(rnd40());
      capture();
      finish_frame(n, 1'b0);
    end

    // buffer full: two words beyond DEPTH are dropped
    rise_dly = 0; busy_len = 1;
    frame.delete();
    for (int i = 0; i < DEPTH + 2; i++) frame.push_back(rnd40());
    capture();
    finish_frame(DEPTH, 1'b1);

    // reset during byte 7 of a full frame
    busy_len = 2;
    frame.delete();
    for (int i = 0; i < DEPTH; i++) frame.push_back(rnd40());
    base = tx_cnt;
    capture();
    wait_tx(base + 7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    epoch++;
    exp_q.delete();
    #1;
    chk("abort_tx_start", 64'(tx_start), 64'(0));
    chk("abort_tx_byte", 64'(tx_byte), 64'(0));
    chk("abort_overflow", 64'(overflow), 64'(0));
    chk("abort_word_count", 64'(word_count), 64'(0));
    chk("abort_frame_done", 64'(frame_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    base = tx_cnt;
    repeat (40) @(negedge clk);
    chk("quiet_after_reset", 64'(tx_cnt - base), 64'(0));
    busy_len = 4;
    frame = '{rnd40(), rnd40(), rnd40()};
    capture();
    finish_frame(3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
